// File: rtl/mult_accum.sv
// mult_accum: per-hardware-thread dot-product accumulator feeding a small output FIFO.
// Optional build macro MULT_ACCUM_SAT_EN: saturating accumulation plus an o_sat flag per result.
module mult_accum #(
  parameter int HT_W       = 4,
  parameter int ACC_W      = 64,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [63:0]      i_res,
  input  logic [HT_W-1:0]  i_htId,
  input  logic             i_vld,
  input  logic [LEN_W-1:0] i_len,
  output logic [ACC_W-1:0] o_res,
  output logic [HT_W-1:0]  o_htId,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic             o_ovf,
  output logic             o_busy
`ifdef MULT_ACCUM_SAT_EN
  ,
  output logic             o_sat
`endif
);

  localparam int N_THR = 2 ** HT_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Per-thread contexts
  logic [ACC_W-1:0] acc [N_THR];
  logic [LEN_W-1:0] cnt [N_THR];
`ifdef MULT_ACCUM_SAT_EN
  logic             sat [N_THR];
  logic [ACC_W:0]   sum_full;
  logic             sum_ovf;
  logic             sat_out;
`endif

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] len_m1;
  logic [ACC_W-1:0] sum;
  logic             last;

  // Output FIFO storage and control
  logic [ACC_W-1:0] mem_res  [FIFO_DEPTH];
  logic [HT_W-1:0]  mem_ht   [FIFO_DEPTH];
`ifdef MULT_ACCUM_SAT_EN
  logic             mem_sat  [FIFO_DEPTH];
`endif
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             ovf_q;
  logic             busy;

  // Accumulate datapath: one context read and one write per cycle, so
  // back-to-back products on a thread always see the freshest sum.
  always_comb begin
    len_eff = (i_len == '0) ? LEN_W'(1) : i_len;
    len_m1  = len_eff - LEN_W'(1);
    last    = (cnt[i_htId] >= len_m1);
`ifdef MULT_ACCUM_SAT_EN
    sum_full = {1'b0, acc[i_htId]} + (ACC_W + 1)'(i_res);
    sum_ovf  = sum_full[ACC_W];
    sum      = sum_ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
    sat_out  = sat[i_htId] | sum_ovf;
`else
    sum      = acc[i_htId] + ACC_W'(i_res);
`endif
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int t = 0; t < N_THR; t++) begin
        acc[t] <= '0;
        cnt[t] <= '0;
`ifdef MULT_ACCUM_SAT_EN
        sat[t] <= 1'b0;
`endif
      end
    end else if (i_vld) begin
      if (last) begin
        acc[i_htId] <= '0;
        cnt[i_htId] <= '0;
`ifdef MULT_ACCUM_SAT_EN
        sat[i_htId] <= 1'b0;
`endif
      end else begin
        acc[i_htId] <= sum;
        cnt[i_htId] <= cnt[i_htId] + LEN_W'(1);
`ifdef MULT_ACCUM_SAT_EN
        sat[i_htId] <= sat_out;
`endif
      end
    end
  end

  // Handshake: the head entry transfers on any posedge where o_vld && i_rdy.
  // o_vld never depends on i_rdy, and a new result is never bypassed to the head.
  always_comb begin
    empty    = (count == '0);
    full     = (count == CNT_W'(FIFO_DEPTH));
    push_req = i_vld && last;
    pop      = !empty && i_rdy;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_res[wr_ptr] <= sum;
        mem_ht[wr_ptr]  <= i_htId;
`ifdef MULT_ACCUM_SAT_EN
        mem_sat[wr_ptr] <= sat_out;
`endif
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int t = 0; t < N_THR; t++) begin
      busy = busy | (cnt[t] != '0);
    end
  end

  always_comb begin
    o_vld  = !empty;
    o_res  = empty ? '0 : mem_res[rd_ptr];
    o_htId = empty ? '0 : mem_ht[rd_ptr];
    o_ovf  = ovf_q;
    o_busy = busy;
`ifdef MULT_ACCUM_SAT_EN
    o_sat  = empty ? 1'b0 : mem_sat[rd_ptr];
`endif
  end

endmodule
